// File: rtl/scrambler_frame_ctrl.sv
// -----------------------------------------------------------------------------
// scrambler_frame_ctrl
//
// Frame-level sequencer for an 8-bit additive LFSR byte scrambler. Accepts a
// framed byte stream (valid/ready with sof/eof), reloads the LFSR from a
// programmable seed at the start of every frame, steps it once per accepted
// byte and presents the scrambled byte through a single registered output
// stage (latency 1, throughput 1 byte/clk).
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready/in_data     plain byte input handshake
//   in_sof/in_eof                 frame delimiters on the input byte
//   out_valid/out_ready/out_data  scrambled byte output handshake
//   out_sof/out_eof               frame delimiters aligned to out_data
//   cfg_seed/cfg_seed_we          seed register write (used at next frame load)
//   cfg_bypass                    only with SCRAMBLER_BYPASS_EN: pass frame unscrambled
//   busy                          FSM not idle
//   frame_cnt/drop_cnt            completed frames / bytes dropped while idle
//
// Build option
//   SCRAMBLER_BYPASS_EN: adds cfg_bypass, sampled at frame load and held for the
//   whole frame. When set, bytes pass through unchanged and the LFSR holds.
// -----------------------------------------------------------------------------
module scrambler_frame_ctrl #(
   parameter logic [7:0]  SEED_DEFAULT = 8'hC5,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic             in_sof,
   input  logic             in_eof,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic             out_sof,
   output logic             out_eof,
   input  logic [7:0]       cfg_seed,
   input  logic             cfg_seed_we,
`ifdef SCRAMBLER_BYPASS_EN
   input  logic             cfg_bypass,
`endif
   output logic             busy,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] drop_cnt
);

   typedef enum logic [1:0] {StIdle, StLoad, StRun, StDrain} state_e;

   state_e           state_q, state_d;
   logic [7:0]       lfsr_q, lfsr_d;
   logic [7:0]       seed_q, seed_d;
   logic             first_q, first_d;
   logic             out_valid_q, out_valid_d;
   logic [7:0]       out_data_q, out_data_d;
   logic             out_sof_q, out_sof_d;
   logic             out_eof_q, out_eof_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   logic [7:0]       lfsr_nxt;
   logic             byp;
   logic             run_rdy;

`ifdef SCRAMBLER_BYPASS_EN
   logic bypass_q, bypass_d;
   assign byp = bypass_q;
`else
   assign byp = 1'b0;
`endif

   assign lfsr_nxt = {lfsr_q[6] ^ lfsr_q[3], lfsr_q[7:1]};

   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      first_d     = first_q;
      out_data_d  = out_data_q;
      out_sof_d   = out_sof_q;
      out_eof_d   = out_eof_q;
      frame_cnt_d = frame_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      in_ready    = 1'b0;
      run_rdy     = 1'b0;
`ifdef SCRAMBLER_BYPASS_EN
      bypass_d    = bypass_q;
`endif
      seed_d      = cfg_seed_we ? cfg_seed : seed_q;
      // Output register empties when taken; refilled below on an accepted byte.
      out_valid_d = out_valid_q & ~out_ready;

      unique case (state_q)
         StIdle: begin
            // Stray bytes outside a frame are swallowed and counted.
            in_ready = in_valid & ~in_sof;
            if (in_valid && !in_sof) begin
               drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end else if (in_valid && in_sof) begin
               state_d = StLoad;
            end
         end
         StLoad: begin
            lfsr_d  = (seed_q == 8'h00) ? SEED_DEFAULT : seed_q;
            first_d = 1'b1;
`ifdef SCRAMBLER_BYPASS_EN
            bypass_d = cfg_bypass;
`endif
            state_d = StRun;
         end
         StRun: begin
            if (in_valid && in_sof && !first_q) begin
               // New sof mid-frame: abandon this frame and restart; byte stays on input.
               state_d = StLoad;
            end else begin
               run_rdy  = ~out_valid_q | out_ready;
               in_ready = run_rdy;
               if (in_valid && run_rdy) begin
                  first_d     = 1'b0;
                  out_valid_d = 1'b1;
                  out_data_d  = byp ? in_data : (in_data ^ lfsr_nxt);
                  out_sof_d   = in_sof;
                  out_eof_d   = in_eof;
                  lfsr_d      = byp ? lfsr_q : lfsr_nxt;
                  if (in_eof) begin
                     state_d = StDrain;
                  end
               end
            end
         end
         StDrain: begin
            if (out_valid_q && out_ready && out_eof_q) begin
               frame_cnt_d = frame_cnt_q + CNT_W'(1);
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         lfsr_q      <= SEED_DEFAULT;
         seed_q      <= SEED_DEFAULT;
         first_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= 8'h00;
         out_sof_q   <= 1'b0;
         out_eof_q   <= 1'b0;
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
`ifdef SCRAMBLER_BYPASS_EN
         bypass_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         seed_q      <= seed_d;
         first_q     <= first_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sof_q   <= out_sof_d;
         out_eof_q   <= out_eof_d;
         frame_cnt_q <= frame_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
`ifdef SCRAMBLER_BYPASS_EN
         bypass_q    <= bypass_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sof   = out_sof_q;
   assign out_eof   = out_eof_q;
   assign busy      = (state_q != StIdle);
   assign frame_cnt = frame_cnt_q;
   assign drop_cnt  = drop_cnt_q;

endmodule
